// File: rtl/ramio_pkg.sv
// rtl/ramio_pkg.sv - shared types and constants for the RAMIO port arbiter
package ramio_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_BYTE = 3'b001;
    localparam logic [2:0] RD_HALF = 3'b010;
    localparam logic [2:0] RD_WORD = 3'b011;
    localparam int         RD_SIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // A request must be a pure read or a pure write.
    function automatic logic req_legal(input logic [1:0] wt, input logic [2:0] rt);
        return (wt != WR_NONE) ^ (rt != RD_NONE);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-grant pointer
module rr_arbiter2 #(
    parameter int RESET_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_q;

    // On a tie, the requester that was not granted last wins.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= (RESET_PRIORITY == 0);
        end else if (accept_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/ramio_arbiter.sv
// rtl/ramio_arbiter.sv - shares the RAMIO port between boot loader and CPU side
module ramio_arbiter
    import ramio_pkg::*;
#(
    parameter int RESET_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [1:0]          req0_write_type,
    input  logic [2:0]          req0_read_type,
    input  logic [ADDR_W-1:0]   req0_address,
    input  logic [DATA_W-1:0]   req0_data_in,
    output logic                req0_done,
    output logic                req0_error,
    output logic [DATA_W-1:0]   req0_data_out,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [1:0]          req1_write_type,
    input  logic [2:0]          req1_read_type,
    input  logic [ADDR_W-1:0]   req1_address,
    input  logic [DATA_W-1:0]   req1_data_in,
    output logic                req1_done,
    output logic                req1_error,
    output logic [DATA_W-1:0]   req1_data_out,
    output logic                ramio_enable,
    output logic [1:0]          ramio_write_type,
    output logic [2:0]          ramio_read_type,
    output logic [ADDR_W-1:0]   ramio_address,
    output logic [DATA_W-1:0]   ramio_data_in,
    input  logic [DATA_W-1:0]   ramio_data_out,
    input  logic                ramio_data_out_ready,
    input  logic                ramio_busy
);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              en_q, en_d;
    logic [1:0]        wt_q, wt_d;
    logic [2:0]        rt_q, rt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] dout0_q, dout0_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic [31:0]       tmo_q, tmo_d;

    logic [1:0]        grant;
    logic              accept;
    logic              sel;
    logic [1:0]        sel_wt;
    logic [2:0]        sel_rt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr_done;
    logic              rd_done;
    logic              timed_out;
    logic [31:0]       tmo_inc;

    rr_arbiter2 #(
        .RESET_PRIORITY (RESET_PRIORITY)
    ) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign accept     = (state_q == ST_IDLE) && !ramio_busy && (grant != 2'b00);
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    assign sel      = grant[1];
    assign sel_wt   = sel ? req1_write_type : req0_write_type;
    assign sel_rt   = sel ? req1_read_type  : req0_read_type;
    assign sel_addr = sel ? req1_address    : req0_address;
    assign sel_data = sel ? req1_data_in    : req0_data_in;

    // The first WAIT cycle is ignored for writes: downstream busy may not have risen yet.
    assign tmo_inc   = tmo_q + 32'(tmo_q != 32'hFFFF_FFFF);
    assign wr_done   = (wt_q != WR_NONE) && (tmo_q != 32'd0) && !ramio_busy;
    assign rd_done   = (rt_q != RD_NONE) && ramio_data_out_ready;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_inc == 32'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        en_d    = en_q;
        wt_d    = wt_q;
        rt_d    = rt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gnt_d = sel;
                    if (req_legal(sel_wt, sel_rt)) begin
                        en_d    = 1'b1;
                        wt_d    = sel_wt;
                        rt_d    = sel_rt;
                        addr_d  = sel_addr;
                        wdata_d = sel_data;
                        tmo_d   = 32'd0;
                        state_d = ST_WAIT;
                    end else begin
                        done_d[sel] = 1'b1;
                        err_d[sel]  = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_inc;
                if (wr_done || rd_done || timed_out) begin
                    en_d          = 1'b0;
                    wt_d          = WR_NONE;
                    rt_d          = RD_NONE;
                    done_d[gnt_q] = 1'b1;
                    state_d       = ST_DONE;
                    if (rd_done) begin
                        if (gnt_q) dout1_d = ramio_data_out;
                        else       dout0_d = ramio_data_out;
                    end else if (!wr_done) begin
                        err_d[gnt_q] = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            en_q    <= 1'b0;
            wt_q    <= WR_NONE;
            rt_q    <= RD_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            dout0_q <= '0;
            dout1_q <= '0;
            tmo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            wt_q    <= wt_d;
            rt_q    <= rt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ramio_enable     = en_q;
    assign ramio_write_type = wt_q;
    assign ramio_read_type  = rt_q;
    assign ramio_address    = addr_q;
    assign ramio_data_in    = wdata_q;
    assign req0_done        = done_q[0];
    assign req1_done        = done_q[1];
    assign req0_error       = err_q[0];
    assign req1_error       = err_q[1];
    assign req0_data_out    = dout0_q;
    assign req1_data_out    = dout1_q;

endmodule

// File: tb/tb_ramio_arbiter.sv
// tb/tb_ramio_arbiter.sv - directed vector bench for ramio_arbiter
module tb_ramio_arbiter;
    import ramio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_write_type = '0, req1_write_type = '0;
    logic [2:0]  req0_read_type = '0, req1_read_type = '0;
    logic [31:0] req0_address = '0, req1_address = '0;
    logic [31:0] req0_data_in = '0, req1_data_in = '0;
    logic        req0_done, req1_done, req0_error, req1_error;
    logic [31:0] req0_data_out, req1_data_out;
    logic        ramio_enable;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address, ramio_data_in, ramio_data_out;
    logic        ramio_data_out_ready, ramio_busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ds_delay = 0;
    int          ds_cnt;
    logic [31:0] ds_rdata = '0;
    logic        busy_force = 1'b0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    ramio_arbiter #(.RESET_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_write_type(req0_write_type), .req0_read_type(req0_read_type),
        .req0_address(req0_address), .req0_data_in(req0_data_in),
        .req0_done(req0_done), .req0_error(req0_error), .req0_data_out(req0_data_out),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_write_type(req1_write_type), .req1_read_type(req1_read_type),
        .req1_address(req1_address), .req1_data_in(req1_data_in),
        .req1_done(req1_done), .req1_error(req1_error), .req1_data_out(req1_data_out),
        .ramio_enable(ramio_enable), .ramio_write_type(ramio_write_type),
        .ramio_read_type(ramio_read_type), .ramio_address(ramio_address),
        .ramio_data_in(ramio_data_in), .ramio_data_out(ramio_data_out),
        .ramio_data_out_ready(ramio_data_out_ready), .ramio_busy(ramio_busy)
    );

    // Downstream model: writes stay busy for ds_delay enable cycles, reads answer
    // in enable cycle ds_delay; a negative delay never answers a read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ds_cnt <= 0;
        else        ds_cnt <= ramio_enable ? ds_cnt + 1 : 0;
    end
    assign ramio_busy = busy_force | (ramio_enable && ramio_write_type != WR_NONE && ds_cnt < ds_delay);
    assign ramio_data_out_ready = ramio_enable && ramio_read_type != RD_NONE && ds_delay >= 0 && ds_cnt == ds_delay;
    assign ramio_data_out = ramio_data_out_ready ? ds_rdata : 32'h0BAD_0BAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) check("both_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
    end

    task automatic drive(input int r, input logic v, input logic [1:0] wt, input logic [2:0] rt,
                         input logic [31:0] a, input logic [31:0] d);
        if (r == 0) begin
            req0_valid = v; req0_write_type = wt; req0_read_type = rt; req0_address = a; req0_data_in = d;
        end else begin
            req1_valid = v; req1_write_type = wt; req1_read_type = rt; req1_address = a; req1_data_in = d;
        end
    endtask

    function automatic logic rdy_of(input int r);
        return (r == 0) ? req0_ready : req1_ready;
    endfunction
    function automatic logic done_of(input int r);
        return (r == 0) ? req0_done : req1_done;
    endfunction

    task automatic do_reset();
        drive(0, 0, '0, '0, '0, '0);
        drive(1, 0, '0, '0, '0, '0);
        busy_force = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          req;
        logic [1:0]  wt;
        logic [2:0]  rt;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        bit   got;
        logic legal;
        ds_delay = v.delay;
        ds_rdata = v.rdata;
        @(posedge clk); #1;
        drive(v.req, 1, v.wt, v.rt, v.addr, v.wdata);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rdy_of(v.req)) got = 1;
        end
        check($sformatf("v%0d_ready", idx), {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        drive(v.req, 0, '0, '0, '0, '0);
        if (!got) return;
        @(negedge clk);
        legal = (v.wt != 2'b00) ^ (v.rt != 3'b000);
        check($sformatf("v%0d_enable", idx), {31'b0, ramio_enable}, {31'b0, legal});
        if (legal) begin
            check($sformatf("v%0d_wtype", idx), {30'b0, ramio_write_type}, {30'b0, v.wt});
            check($sformatf("v%0d_rtype", idx), {29'b0, ramio_read_type}, {29'b0, v.rt});
            check($sformatf("v%0d_addr", idx), ramio_address, v.addr);
            check($sformatf("v%0d_wdata", idx), ramio_data_in, v.wdata);
        end
        n = 1;
        got = done_of(v.req);
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = done_of(v.req);
        end
        check($sformatf("v%0d_latency", idx), n, v.exp_lat);
        check($sformatf("v%0d_error", idx), {31'b0, (v.req == 0) ? req0_error : req1_error}, {31'b0, v.exp_err});
        check($sformatf("v%0d_rdata", idx), (v.req == 0) ? req0_data_out : req1_data_out, v.exp_rd);
        check($sformatf("v%0d_other_done", idx), {31'b0, done_of(1 - v.req)}, 32'd0);
        check($sformatf("v%0d_enable_off", idx), {31'b0, ramio_enable}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), {31'b0, done_of(v.req)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   grants[$];
        bit   got;

        vecs[0] = '{0, WR_WORD, RD_NONE, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 3, 32'h0};
        vecs[1] = '{1, WR_NONE, RD_HALF, 32'h4, 32'h0, 3, 32'h0000_4120, 1'b0, 5, 32'h0000_4120};
        vecs[2] = '{0, WR_WORD, RD_WORD, 32'h8, 32'h1, 0, 32'h0, 1'b1, 1, 32'h0};
        vecs[3] = '{1, WR_NONE, RD_NONE, 32'hC, 32'h2, 0, 32'h0, 1'b1, 1, 32'h0000_4120};
        vecs[4] = '{1, WR_BYTE, RD_NONE, 32'h20, 32'hA5, 3, 32'h0, 1'b0, 5, 32'h0000_4120};
        vecs[5] = '{0, WR_NONE, 3'b101, 32'h21, 32'h0, 1, 32'hFFFF_FF80, 1'b0, 3, 32'hFFFF_FF80};
        vecs[6] = '{0, WR_NONE, RD_WORD, 32'h30, 32'h0, -1, 32'h0, 1'b1, 9, 32'hFFFF_FF80};
        vecs[7] = '{1, WR_NONE, RD_WORD, 32'h34, 32'h0, 0, 32'h1234_5678, 1'b0, 2, 32'h1234_5678};
        vecs[8] = '{0, WR_HALF, RD_NONE, 32'h2, 32'hBEEF, 1, 32'h0, 1'b0, 3, 32'hFFFF_FF80};

        do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_enable", {31'b0, ramio_enable}, 32'd0);
        check("reset_types", {27'b0, ramio_write_type, ramio_read_type}, 32'd0);
        check("reset_addr_data", ramio_address | ramio_data_in, 32'd0);
        check("reset_done_err", {28'b0, req0_done, req1_done, req0_error, req1_error}, 32'd0);
        check("reset_data_out", req0_data_out | req1_data_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Busy in IDLE holds off the grant.
        ds_delay = 0;
        busy_force = 1'b1;
        @(posedge clk); #1;
        drive(0, 1, WR_WORD, RD_NONE, 32'h40, 32'h55);
        repeat (3) begin
            @(negedge clk);
            check("busy_blocks_ready", {31'b0, req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        busy_force = 1'b0;
        @(negedge clk);
        check("busy_release_ready", {31'b0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        drive(0, 0, '0, '0, '0, '0);
        repeat (6) @(negedge clk);

        // Both requesters valid from reset: grants alternate starting at 0.
        do_reset();
        @(posedge clk); #1;
        drive(0, 1, WR_WORD, RD_NONE, 32'h100, 32'h1);
        drive(1, 1, WR_WORD, RD_NONE, 32'h200, 32'h2);
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1;
        drive(0, 0, '0, '0, '0, '0);
        drive(1, 0, '0, '0, '0, '0);
        check("rr_grant_count", grants.size(), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check($sformatf("rr_grant%0d", i), grants[i], i % 2);
        repeat (6) @(negedge clk);

        // Reset in the middle of WAIT: silent abort, tie priority restored.
        ds_delay = -1;
        @(posedge clk); #1;
        drive(0, 1, WR_NONE, RD_WORD, 32'h300, 32'h0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req0_ready;
        end
        check("midwait_ready", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        drive(0, 0, '0, '0, '0, '0);
        @(negedge clk);
        check("midwait_enable", {31'b0, ramio_enable}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_enable", {31'b0, ramio_enable}, 32'd0);
        check("midwait_rst_outputs", {27'b0, ramio_write_type, ramio_read_type} | ramio_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req0_done || req1_done) got = 1;
        end
        check("midwait_no_done", {31'b0, got}, 32'd0);
        ds_delay = 0;
        @(posedge clk); #1;
        drive(0, 1, WR_WORD, RD_NONE, 32'h400, 32'h4);
        drive(1, 1, WR_WORD, RD_NONE, 32'h500, 32'h5);
        @(negedge clk);
        check("post_reset_tie", {30'b0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk); #1;
        drive(0, 0, '0, '0, '0, '0);
        drive(1, 0, '0, '0, '0, '0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = req0_done;
        end
        check("post_reset_done", {31'b0, got}, 32'd1);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
